// File: rtl/div_arbiter.sv
// rtl/div_arbiter.sv - round-robin sharing of one iterative unsigned divider among NREQ requesters
// Optional zero-divisor bypass: define DIV_ZERO_BYPASS_EN.
module div_arbiter #(
    parameter int NREQ = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [32*NREQ-1:0]   a_in,
    input  logic [32*NREQ-1:0]   b_in,
    output logic [NREQ-1:0]      done,
    output logic [31:0]          res_q,
    output logic [31:0]          res_r,
    output logic                 res_err,
    output logic                 busy,
    output logic                 div_start,
    output logic [31:0]          div_a,
    output logic [31:0]          div_b,
    input  logic [31:0]          div_q,
    input  logic [31:0]          div_r,
    input  logic                 div_ok
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      grant_q, grant_d;
    logic [NREQ-1:0]    done_q, done_d;
    logic [31:0]        quo_q, quo_d;
    logic [31:0]        rem_q, rem_d;
    logic               err_q, err_d;
    logic               start_q, start_d;
    logic [31:0]        opa_q, opa_d;
    logic [31:0]        opb_q, opb_d;

    logic [31:0]        a_arr [NREQ];
    logic [31:0]        b_arr [NREQ];
    logic               found;
    logic [IW-1:0]      win;
    int                 cand;

    genvar gi;
    for (gi = 0; gi < NREQ; gi++) begin : g_ops
        assign a_arr[gi] = a_in[32*gi +: 32];
        assign b_arr[gi] = b_in[32*gi +: 32];
    end

    // First set request strictly after the last grant, wrapping around.
    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        cand  = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= NREQ) cand = cand - NREQ;
            if (!found && req[IW'(cand)]) begin
                found = 1'b1;
                win   = IW'(cand);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        done_d  = '0;
        quo_d   = quo_q;
        rem_d   = rem_q;
        err_d   = err_q;
        start_d = 1'b0;
        opa_d   = opa_q;
        opb_d   = opb_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = win;
                    ptr_d   = win;
                    opa_d   = a_arr[win];
                    opb_d   = b_arr[win];
`ifdef DIV_ZERO_BYPASS_EN
                    if (b_arr[win] == 32'd0) begin
                        quo_d   = 32'hFFFF_FFFF;
                        rem_d   = a_arr[win];
                        err_d   = 1'b1;
                        done_d  = NREQ'(1) << win;
                        state_d = DONE;
                    end else begin
                        start_d = 1'b1;
                        state_d = LAUNCH;
                    end
`else
                    start_d = 1'b1;
                    state_d = LAUNCH;
`endif
                end
            end
            // div_ok is still high from the previous idle period here.
            LAUNCH: state_d = WAIT;
            WAIT: begin
                if (div_ok) begin
                    quo_d   = div_q;
                    rem_d   = div_r;
                    err_d   = (opb_q == 32'd0);
                    done_d  = NREQ'(1) << grant_q;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= IW'(NREQ - 1);
            grant_q <= '0;
            done_q  <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
            start_q <= start_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
        end
    end

    assign done      = done_q;
    assign res_q     = quo_q;
    assign res_r     = rem_q;
    assign res_err   = err_q;
    assign busy      = (state_q != IDLE);
    assign div_start = start_q;
    assign div_a     = opa_q;
    assign div_b     = opb_q;

endmodule

// File: tb/tb_div_arbiter.sv
// tb/tb_div_arbiter.sv - self-checking bench for div_arbiter with a behavioural divider and round-robin model
module tb_div_arbiter;

    localparam int NREQ = 4;
`ifdef DIV_ZERO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset;
    logic [NREQ-1:0]    req;
    logic [32*NREQ-1:0] a_in, b_in;
    logic [NREQ-1:0]    done;
    logic [31:0]        res_q, res_r;
    logic               res_err, busy, div_start;
    logic [31:0]        div_a, div_b;
    logic [31:0]        div_q, div_r;
    logic               div_ok;

    int n_cmp = 0;
    int n_bad = 0;
    int starts = 0;
    int dcnt;

    div_arbiter #(.NREQ(NREQ)) dut (
        .clk(clk), .reset(reset), .req(req), .a_in(a_in), .b_in(b_in),
        .done(done), .res_q(res_q), .res_r(res_r), .res_err(res_err), .busy(busy),
        .div_start(div_start), .div_a(div_a), .div_b(div_b),
        .div_q(div_q), .div_r(div_r), .div_ok(div_ok)
    );

    always #5 clk = ~clk;

    // Stand-in divider: 32 busy cycles after a start, zero divisor gives all-ones / dividend.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            div_ok <= 1'b1; dcnt <= 0; div_q <= '0; div_r <= '0;
        end else if (div_ok && div_start) begin
            div_ok <= 1'b0;
            dcnt   <= 32;
            div_q  <= (div_b == 0) ? 32'hFFFF_FFFF : div_a / div_b;
            div_r  <= (div_b == 0) ? div_a : div_a % div_b;
        end else if (!div_ok) begin
            dcnt <= dcnt - 1;
            if (dcnt == 1) div_ok <= 1'b1;
        end
    end

    always @(negedge clk) if (div_start === 1'b1) starts++;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_done(input int max, output int lat);
        lat = -1;
        for (int c = 1; c <= max; c++) begin
            @(negedge clk);
            if (done !== '0) begin
                lat = c;
                break;
            end
        end
        if (lat < 0) chk("done_timeout", 32'hDEAD, 32'h0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [31:0] ref_q(input logic [31:0] a, input logic [31:0] b);
        return (b == 0) ? 32'hFFFF_FFFF : a / b;
    endfunction

    function automatic logic [31:0] ref_r(input logic [31:0] a, input logic [31:0] b);
        return (b == 0) ? a : a % b;
    endfunction

    // Random batch: every requester has a few ops and re-requests right after each done.
    task automatic run_batch();
        logic [31:0] opa [NREQ][3];
        logic [31:0] opb [NREQ][3];
        int cnt [NREQ];
        int rem [NREQ];
        int sent [NREQ];
        int exp_idx [$];
        logic [31:0] exp_a [$];
        logic [31:0] exp_b [$];
        int total, last, k, n, cyc, prev, s0, exp_starts, gap, limit;
        total = 0;
        exp_starts = 0;
        for (int i = 0; i < NREQ; i++) begin
            cnt[i] = int'($urandom_range(1, 3));
            rem[i] = cnt[i];
            sent[i] = 0;
            total += cnt[i];
            for (int j = 0; j < 3; j++) begin
                opa[i][j] = $urandom;
                case ($urandom_range(0, 3))
                    0: opb[i][j] = 32'd0;
                    1: opb[i][j] = $urandom_range(1, 15);
                    2: opb[i][j] = $urandom;
                    default: opb[i][j] = $urandom_range(1, 1000);
                endcase
            end
        end
        last = NREQ - 1;
        for (int m = 0; m < total; m++) begin
            k = last;
            for (int s = 1; s <= NREQ; s++) begin
                if (rem[(last + s) % NREQ] > 0) begin
                    k = (last + s) % NREQ;
                    break;
                end
            end
            exp_idx.push_back(k);
            exp_a.push_back(opa[k][cnt[k] - rem[k]]);
            exp_b.push_back(opb[k][cnt[k] - rem[k]]);
            if (!(BYP && opb[k][cnt[k] - rem[k]] == 0)) exp_starts++;
            rem[k]--;
            last = k;
        end

        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            a_in[32*i +: 32] = opa[i][0];
            b_in[32*i +: 32] = opb[i][0];
        end
        s0 = starts;
        req = '1;
        n = 0; cyc = 0; prev = 0;
        limit = total * 40 + 100;
        while (n < total && cyc < limit) begin
            @(negedge clk);
            cyc++;
            if (done !== '0) begin
                k = exp_idx[n];
                if (BYP && exp_b[n] == 0) gap = (n == 0) ? 1 : 2;
                else gap = (n == 0) ? 35 : 36;
                chk("rr_done", 32'(done), 32'(1 << k));
                chk("rr_q", res_q, ref_q(exp_a[n], exp_b[n]));
                chk("rr_r", res_r, ref_r(exp_a[n], exp_b[n]));
                chk("rr_err", 32'(res_err), 32'(exp_b[n] == 0));
                chk("rr_gap", 32'(cyc - prev), 32'(gap));
                prev = cyc;
                n++;
                sent[k]++;
                if (sent[k] < cnt[k]) begin
                    a_in[32*k +: 32] = opa[k][sent[k]];
                    b_in[32*k +: 32] = opb[k][sent[k]];
                end else begin
                    req[k] = 1'b0;
                end
            end
        end
        chk("rr_all_served", 32'(n), 32'(total));
        chk("rr_starts", 32'(starts - s0), 32'(exp_starts));
        req = '0;
        @(negedge clk);
    endtask

    typedef struct {
        int          idx;
        logic [31:0] a, b, q, r;
        logic        err;
        int          lat;
    } vec_t;

    vec_t tv [9];
    int lat, s0, nd;

    initial begin
        tv[0] = '{0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 35};
        tv[1] = '{1, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 35};
        tv[2] = '{2, 32'd9, 32'd4, 32'd2, 32'd1, 1'b0, 35};
        tv[3] = '{3, 32'd12345, 32'd0, 32'hFFFF_FFFF, 32'd12345, 1'b1, BYP ? 1 : 35};
        tv[4] = '{0, 32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 35};
        tv[5] = '{3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 35};
        tv[6] = '{1, 32'd7, 32'd9, 32'd0, 32'd7, 1'b0, 35};
        tv[7] = '{2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 1'b1, BYP ? 1 : 35};
        tv[8] = '{1, 32'd1000000, 32'd3, 32'd333333, 32'd1, 1'b0, 35};

        a_in = '0;
        b_in = '0;
        reset = 1'b1;
        req = '0;
        repeat (3) @(negedge clk);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_res_q", res_q, 32'h0);
        chk("rst_res_r", res_r, 32'h0);
        chk("rst_err", 32'(res_err), 32'h0);
        chk("rst_start", 32'(div_start), 32'h0);
        chk("rst_div_a", div_a, 32'h0);
        chk("rst_div_b", div_b, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            s0 = starts;
            a_in[32*tv[i].idx +: 32] = tv[i].a;
            b_in[32*tv[i].idx +: 32] = tv[i].b;
            req = 4'b0001 << tv[i].idx;
            wait_done(60, lat);
            chk("tv_done", 32'(done), 32'(1 << tv[i].idx));
            chk("tv_q", res_q, tv[i].q);
            chk("tv_r", res_r, tv[i].r);
            chk("tv_err", 32'(res_err), 32'(tv[i].err));
            chk("tv_lat", 32'(lat), 32'(tv[i].lat));
            chk("tv_starts", 32'(starts - s0), (BYP && tv[i].b == 0) ? 32'd0 : 32'd1);
            req = '0;
            @(negedge clk);
            chk("tv_idle", 32'(busy), 32'h0);
            chk("tv_hold_q", res_q, tv[i].q);
            chk("tv_done_clr", 32'(done), 32'h0);
        end

        // Two simultaneous requests right after reset: 1 before 2.
        do_reset();
        a_in[32 +: 32] = 32'd50; b_in[32 +: 32] = 32'd5;
        a_in[64 +: 32] = 32'd9;  b_in[64 +: 32] = 32'd4;
        req = 4'b0110;
        wait_done(60, lat);
        chk("pair1_done", 32'(done), 32'h2);
        chk("pair1_q", res_q, 32'd10);
        chk("pair1_r", res_r, 32'd0);
        chk("pair1_lat", 32'(lat), 32'd35);
        req[1] = 1'b0;
        wait_done(60, lat);
        chk("pair2_done", 32'(done), 32'h4);
        chk("pair2_q", res_q, 32'd2);
        chk("pair2_r", res_r, 32'd1);
        chk("pair2_lat", 32'(lat), 32'd36);
        req = '0;
        @(negedge clk);

        // Reset while the divider is busy.
        a_in[0 +: 32] = 32'd100; b_in[0 +: 32] = 32'd7;
        req = 4'b0001;
        repeat (10) @(negedge clk);
        chk("midrst_busy_before", 32'(busy), 32'h1);
        reset = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_done", 32'(done), 32'h0);
        chk("midrst_res_q", res_q, 32'h0);
        chk("midrst_res_r", res_r, 32'h0);
        chk("midrst_div_a", div_a, 32'h0);
        chk("midrst_div_b", div_b, 32'h0);
        chk("midrst_start", 32'(div_start), 32'h0);
        repeat (2) begin
            @(negedge clk);
            chk("midrst_no_done", 32'(done), 32'h0);
        end
        reset = 1'b0;
        wait_done(60, lat);
        chk("postrst_done", 32'(done), 32'h1);
        chk("postrst_lat", 32'(lat), 32'd35);
        chk("postrst_q", res_q, 32'd14);
        chk("postrst_r", res_r, 32'd2);
        req = '0;
        @(negedge clk);

        // Request dropped mid-operation still completes.
        a_in[0 +: 32] = 32'hFFFF_FFFF; b_in[0 +: 32] = 32'd1;
        req = 4'b0001;
        repeat (5) @(negedge clk);
        req = '0;
        wait_done(60, lat);
        chk("drop_lat", 32'(lat + 5), 32'd35);
        chk("drop_done", 32'(done), 32'h1);
        chk("drop_q", res_q, 32'hFFFF_FFFF);
        chk("drop_r", res_r, 32'd0);
        @(negedge clk);
        chk("drop_idle", 32'(busy), 32'h0);
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (done !== '0) nd++;
        end
        chk("drop_no_more_done", 32'(nd), 32'd0);

        for (int b = 0; b < 4; b++) run_batch();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/div_arbiter.md
Name: div_arbiter

Overview:
Round-robin controller that shares one 32-bit iterative unsigned divider among NREQ requesters. It arbitrates between requests, latches the winner's operands, and sequences the divider's start/ok handshake. It returns quotient, remainder and error on a shared result bus with a one-cycle per-requester done strobe. It sits between client blocks and a single divider instance.

Parameters:
NREQ, 4, number of requesters (2..8); the index width IW = clog2(NREQ) is derived internally.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req  in  NREQ  per-requester request level; operands must be held stable while high
a_in  in  32*NREQ  dividends; requester i uses bits [32i+31:32i]
b_in  in  32*NREQ  divisors; same packing as a_in
done  out  NREQ  one-hot, one-cycle completion strobe
res_q  out  32  quotient; valid while a done bit is high, held otherwise
res_r  out  32  remainder; same validity as res_q
res_err  out  1  divide-by-zero flag; same validity as res_q
busy  out  1  high whenever the FSM is not in IDLE
div_start  out  1  one-cycle start pulse to the divider
div_a  out  32  latched dividend to the divider
div_b  out  32  latched divisor to the divider
div_q  in  32  divider quotient
div_r  in  32  divider remainder
div_ok  in  1  divider idle/result-valid; goes low on the cycle after div_start

Behaviour:
- Clock and reset: clk is the clock; reset is asynchronous and active-high.
- Reset values: FSM=IDLE; done=0; res_q=0; res_r=0; res_err=0; div_start=0; div_a=0; div_b=0; rr pointer=NREQ-1, so requester 0 has first priority.
- FSM states: IDLE, LAUNCH, WAIT, DONE.
- IDLE:
  - If any req bit is set, grant the first set bit searching upward, with wrap, from pointer+1.
  - Latch the grant index, a_in and b_in of the winner into div_a and div_b; set pointer=grant.
  - Go to LAUNCH (or to DONE via bypass, see Optional Feature).
- LAUNCH: div_start=1 for exactly this cycle. div_ok is ignored here because it is still high. Go to WAIT.
- WAIT:
  - Hold while div_ok=0.
  - On div_ok=1, register res_q=div_q and res_r=div_r, and set res_err=(div_b==0). Go to DONE.
- DONE: done[grant]=1 for this one cycle. Go to IDLE.
- Timing:
  - Request seen in IDLE at cycle G: div_start at G+1, divider busy G+2..G+33, div_ok=1 at G+34, done at G+35.
  - Next grant earliest at G+36.
- Requester rule: deassert req, or present new operands, no later than the cycle after done.
  - A registered response satisfies this, because IDLE samples req at done+1.
- req dropped mid-operation: the operation still completes and done still pulses; the result is discarded by the requester. No abort is provided.
- Outputs between operations: res_* hold their last values. div_a and div_b hold until the next grant.
- Multiple simultaneous requests: served strictly round-robin, so no requester waits more than NREQ-1 operations.
- Reset mid-operation: FSM returns to IDLE immediately. No done strobe is issued. The divider shares the same reset.

Optional Feature:
Macro DIV_ZERO_BYPASS_EN.
- Defined:
  - In IDLE, if the winner's divisor is 0, skip LAUNCH and WAIT.
  - Set res_q=32'hFFFFFFFF, res_r=dividend, res_err=1, and go to DONE directly.
  - done asserts at G+1; the divider is not started.
- Not defined:
  - Zero divisors go through the divider normally.
  - The divider yields q=FFFFFFFF and r=dividend; res_err=1.
  - done asserts at G+35.
- Result values are identical in both builds; only latency differs.

Test Plan:
1. req=0001, a0=100, b0=7 -> div_start one cycle later; done=0001 exactly 35 cycles after req sampled; q=14, r=2, err=0.
2. req=0110 in the same cycle, a1=50/b1=5, a2=9/b2=4 -> done=0010 first (q=10, r=0), then done=0100 (q=2, r=1); grant order 1,2.
3. All four requesting continuously, with each re-requesting immediately after its done -> completion order 0,1,2,3,0,1, with no requester repeated before all others are served.
4. a0=12345, b0=0 -> q=FFFFFFFF, r=12345, err=1; done after 1 cycle with DIV_ZERO_BYPASS_EN, after 35 without; div_start never asserted with the macro.
5. Assert reset during WAIT (cycle G+10) -> done stays 0, busy=0 and all outputs at reset values; a fresh req then completes normally in 35 cycles.
6. req0 dropped at G+5 during an op with a0=0xFFFFFFFF, b0=1 -> done=0001 still pulses at G+35 with q=FFFFFFFF, r=0; FSM returns to IDLE.
